// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: valid/ready data-memory request bus with a single response channel
interface mem_stage_ctrl_if #(parameter int ADDR_W = 32);
  logic valid;
  logic ready;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [3:0] be;
  logic [31:0] wdata;
  logic rvalid;
  logic [31:0] rdata;
  modport master (output valid, we, addr, be, wdata, input ready, rvalid, rdata);
  modport slave (input valid, we, addr, be, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage load/store sequencer with stall control and load extension.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module mem_stage_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_read_in,
  input  logic mem_write_in,
  input  logic [2:0] funct3_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic stall_out,
  output logic [31:0] load_data_out,
  output logic load_valid_out,
  output logic misalign_out,
  mem_stage_ctrl_if.master dmem,
  output logic [CNT_W-1:0] stall_cnt_out
);
  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
  state_t state, state_nxt;
  logic access, is_b, is_h, mis;
  logic [1:0] off;
  logic [3:0] be_st;
  logic [31:0] wd_st;
  logic we_q, mis_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] be_q;
  logic [31:0] wdata_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  assign access = mem_read_in | mem_write_in;
  assign off = addr_in[1:0];
  // funct3[1:0] carries the size; 11 and 10 fall through to word
  assign is_b = funct3_in[1:0] == 2'b00;
  assign is_h = funct3_in[1:0] == 2'b01;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic is_w;
  assign is_w = ~is_b & ~is_h;
  assign mis = (is_h & off[0]) | (is_w & |off);
`else
  assign mis = 1'b0;
`endif
  assign be_st = is_b ? 4'b0001 << off : is_h ? 4'b0011 << {off[1], 1'b0} : 4'hF;
  assign wd_st = is_b ? {4{wdata_in[7:0]}} : is_h ? {2{wdata_in[15:0]}} : wdata_in;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (access ? (mis ? DONE : REQ) : IDLE) :
                state == REQ  ? (dmem.ready ? RSP : REQ) :
                state == RSP  ? (dmem.rvalid ? DONE : RSP) : IDLE;
  end
  always_comb begin
    stall_out = (state == IDLE & access) | state == REQ | state == RSP;
    dmem.valid = state == REQ;
    load_valid_out = state == DONE & ~we_q & ~mis_q;
    misalign_out = state == DONE & mis_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      we_q <= 1'b0;
      mis_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      f3_q <= '0;
      off_q <= '0;
    end else if (state == IDLE && access) begin
      we_q <= mem_write_in;
      mis_q <= mis;
      addr_q <= {addr_in[ADDR_W-1:2], 2'b00};
      be_q <= mem_write_in ? be_st : 4'hF;
      wdata_q <= wd_st;
      f3_q <= funct3_in;
      off_q <= off;
    end
  assign dmem.we = we_q;
  assign dmem.addr = addr_q;
  assign dmem.be = be_q;
  assign dmem.wdata = wdata_q;
  assign ld_b = off_q == 2'd0 ? dmem.rdata[7:0] : off_q == 2'd1 ? dmem.rdata[15:8] :
                off_q == 2'd2 ? dmem.rdata[23:16] : dmem.rdata[31:24];
  assign ld_h = off_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
  assign ld_ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & ld_b[7]}}, ld_b} :
                  f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & ld_h[15]}}, ld_h} : dmem.rdata;
  always_ff @(posedge clk)
    if (!rst_n) load_data_out <= '0;
    else if (state == RSP && dmem.rvalid && !we_q) load_data_out <= ld_ext;
  always_ff @(posedge clk)
    if (!rst_n) stall_cnt_out <= '0;
    else if (stall_out && !(&stall_cnt_out)) stall_cnt_out <= stall_cnt_out + CNT_W'(1);
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed checks of mem_stage_ctrl handshake, alignment, extension and stall count
module tb_mem_stage_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic mem_read_in, mem_write_in;
  logic [2:0] funct3_in;
  logic [31:0] addr_in, wdata_in;
  logic stall_out, load_valid_out, misalign_out;
  logic [31:0] load_data_out;
  logic [31:0] stall_cnt_out;
  int checks = 0;
  int errors = 0;
  mem_stage_ctrl_if #(.ADDR_W(32)) dmem();
  mem_stage_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in),
    .funct3_in(funct3_in),
    .addr_in(addr_in),
    .wdata_in(wdata_in),
    .stall_out(stall_out),
    .load_data_out(load_data_out),
    .load_valid_out(load_valid_out),
    .misalign_out(misalign_out),
    .dmem(dmem.master),
    .stall_cnt_out(stall_cnt_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    mem_read_in = rd;
    mem_write_in = wr;
    funct3_in = f3;
    addr_in = a;
    wdata_in = wd;
    #1;
    check("idle_stall", stall_out, 1'b1);
    check("idle_valid", dmem.valid, 1'b0);
    step();
  endtask
  task automatic finish(input logic [31:0] rd_data);
    dmem.ready = 1'b1;
    step();
    dmem.ready = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata = rd_data;
    step();
    dmem.rvalid = 1'b0;
    mem_read_in = 1'b0;
    mem_write_in = 1'b0;
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    mem_read_in = 1'b0;
    mem_write_in = 1'b0;
    funct3_in = 3'b000;
    addr_in = '0;
    wdata_in = '0;
    dmem.ready = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_stall", stall_out, 1'b0);
    check("rst_valid", dmem.valid, 1'b0);
    check("rst_ldata", load_data_out, 32'h0);
    check("rst_lvalid", load_valid_out, 1'b0);
    check("rst_mis", misalign_out, 1'b0);
    check("rst_cnt", stall_cnt_out, 32'd0);
    check("rst_be", dmem.be, 4'h0);
    // LW 0x100, minimum latency
    start(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    check("lw_valid", dmem.valid, 1'b1);
    check("lw_addr", dmem.addr, 32'h100);
    check("lw_be", dmem.be, 4'hF);
    check("lw_we", dmem.we, 1'b0);
    check("lw_stall_req", stall_out, 1'b1);
    finish(32'hDEADBEEF);
    check("lw_done_stall", stall_out, 1'b0);
    check("lw_lvalid", load_valid_out, 1'b1);
    check("lw_ldata", load_data_out, 32'hDEADBEEF);
    check("lw_cnt", stall_cnt_out, 32'd3);
    step();
    check("lw_idle_lvalid", load_valid_out, 1'b0);
    check("lw_hold", load_data_out, 32'hDEADBEEF);
    // LB / LBU at offset 3
    start(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    check("lb_addr", dmem.addr, 32'h100);
    finish(32'h80123456);
    check("lb_ldata", load_data_out, 32'hFFFFFF80);
    step();
    start(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
    finish(32'h80123456);
    check("lbu_ldata", load_data_out, 32'h00000080);
    check("lbu_cnt", stall_cnt_out, 32'd9);
    step();
    // SH at 0x102
    start(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD);
    check("sh_we", dmem.we, 1'b1);
    check("sh_be", dmem.be, 4'b1100);
    check("sh_wdata", dmem.wdata, 32'hABCDABCD);
    check("sh_addr", dmem.addr, 32'h100);
    finish(32'h0);
    check("sh_lvalid", load_valid_out, 1'b0);
    check("sh_ldata_hold", load_data_out, 32'h00000080);
    check("sh_cnt", stall_cnt_out, 32'd12);
    step();
    // SB at 0x101
    start(1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5);
    check("sb_be", dmem.be, 4'b0010);
    check("sb_wdata", dmem.wdata, 32'hA5A5A5A5);
    finish(32'h0);
    step();
    // LHU at 0x102
    start(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
    check("lhu_be", dmem.be, 4'hF);
    finish(32'h80017777);
    check("lhu_ldata", load_data_out, 32'h00008001);
    check("lhu_cnt", stall_cnt_out, 32'd18);
    step();
    // Back-pressure: ready low 5 cycles (incl. IDLE), rvalid after 2 more RSP cycles
    start(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      dmem.rvalid = (i == 1);
      #1;
      check("bp_req_valid", dmem.valid, 1'b1);
      check("bp_req_addr", dmem.addr, 32'h200);
      check("bp_req_stall", stall_out, 1'b1);
      step();
    end
    dmem.rvalid = 1'b0;
    dmem.ready = 1'b1;
    #1;
    check("bp_req_still", dmem.valid, 1'b1);
    step();
    for (int i = 0; i < 2; i++) begin
      check("bp_rsp_valid", dmem.valid, 1'b0);
      check("bp_rsp_stall", stall_out, 1'b1);
      step();
    end
    dmem.ready = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata = 32'h00005A5A;
    step();
    dmem.rvalid = 1'b0;
    mem_read_in = 1'b0;
    #1;
    check("bp_lvalid", load_valid_out, 1'b1);
    check("bp_ldata", load_data_out, 32'h00005A5A);
    check("bp_cnt", stall_cnt_out, 32'd27);
    step();
    // Reset during RSP, late response dropped
    start(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    dmem.ready = 1'b1;
    step();
    dmem.ready = 1'b0;
    check("rr_rsp_stall", stall_out, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mem_read_in = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata = 32'hFFFFFFFF;
    #1;
    check("rr_stall", stall_out, 1'b0);
    check("rr_valid", dmem.valid, 1'b0);
    check("rr_cnt", stall_cnt_out, 32'd0);
    check("rr_addr", dmem.addr, 32'h0);
    check("rr_ldata", load_data_out, 32'h0);
    step();
    dmem.rvalid = 1'b0;
    check("rr_drop_ldata", load_data_out, 32'h0);
    check("rr_drop_lvalid", load_valid_out, 1'b0);
    check("rr_drop_cnt", stall_cnt_out, 32'd0);
    // Misaligned LW at 0x101
    mem_read_in = 1'b1;
    funct3_in = 3'b010;
    addr_in = 32'h101;
    #1;
    check("mis_idle_stall", stall_out, 1'b1);
`ifdef DMEM_MISALIGN_TRAP_EN
    step();
    mem_read_in = 1'b0;
    #1;
    check("mis_valid", dmem.valid, 1'b0);
    check("mis_pulse", misalign_out, 1'b1);
    check("mis_done_stall", stall_out, 1'b0);
    check("mis_lvalid", load_valid_out, 1'b0);
    check("mis_ldata", load_data_out, 32'h0);
    check("mis_cnt", stall_cnt_out, 32'd1);
    step();
    check("mis_clear", misalign_out, 1'b0);
`else
    step();
    check("mis_valid", dmem.valid, 1'b1);
    check("mis_addr", dmem.addr, 32'h100);
    check("mis_flag", misalign_out, 1'b0);
    finish(32'hCAFEF00D);
    check("mis_ldata", load_data_out, 32'hCAFEF00D);
    check("mis_flag_done", misalign_out, 1'b0);
    check("mis_cnt", stall_cnt_out, 32'd3);
    step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
